// File: rtl/wts_adsr_envelope_generator_nch.sv
// Time-multiplexed ADSR envelope generator: CHANNELS independent envelopes.
// Each channel ticks only in its own slot and reports its level and phase through one shared output register.
module wts_adsr_ch #(
  parameter int ENV_BITS  = 7,
  parameter int RATE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 svc,
  input  logic                 key_on,
  input  logic                 key_release,
  input  logic                 key_off,
  input  logic                 retrig,
  input  logic [RATE_BITS-1:0] ar,
  input  logic [RATE_BITS-1:0] dr,
  input  logic [RATE_BITS-1:0] sr,
  input  logic [RATE_BITS-1:0] rr,
  input  logic [ENV_BITS-2:0]  sl,
  output logic [ENV_BITS-1:0]  lvl_nxt,
  output logic [2:0]           st_nxt
);
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } st_e;

  localparam logic [ENV_BITS-1:0] MAX = {1'b1, {(ENV_BITS-1){1'b0}}};

  st_e                  st, st_n;
  logic [ENV_BITS-1:0]  lvl, lvl_n, lvl_inc, lvl_dec;
  logic [RATE_BITS-1:0] cnt, cnt_n, rate, cnt_adv;
  logic [RATE_BITS:0]   cnt_inc;
  logic                 fire;

  always_comb begin
    rate = '0;
    case (st)
      ST_ATTACK:  rate = ar;
      ST_DECAY:   rate = dr;
      ST_SUSTAIN: rate = sr;
      ST_RELEASE: rate = rr;
      default:    rate = '0;
    endcase
  end

  // >= rather than == so that a rate lowered mid-phase still fires.
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign fire    = (rate != '0) && (cnt_inc >= {1'b0, rate});
  assign cnt_adv = fire ? '0 : ((rate != '0) ? cnt_inc[RATE_BITS-1:0] : cnt);
  assign lvl_inc = lvl + 1'b1;
  assign lvl_dec = lvl - 1'b1;

  always_comb begin
    st_n  = st;
    lvl_n = lvl;
    cnt_n = cnt;
    if (key_off) begin
      st_n  = ST_IDLE;
      lvl_n = '0;
      cnt_n = '0;
    end else if (key_on) begin
      cnt_n = '0;
      lvl_n = retrig ? lvl : '0;
      if (ar == '0) begin
        lvl_n = MAX;
        st_n  = ST_DECAY;
      end else begin
        st_n  = ST_ATTACK;
      end
    end else if (key_release) begin
      if (st == ST_ATTACK || st == ST_DECAY || st == ST_SUSTAIN) begin
        st_n  = ST_RELEASE;
        cnt_n = '0;
      end
    end else if (svc) begin
      case (st)
        ST_ATTACK: begin
          if (lvl >= MAX) begin
            st_n  = ST_DECAY;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_adv;
            if (fire) begin
              lvl_n = lvl_inc;
              if (lvl_inc == MAX) st_n = ST_DECAY;
            end
          end
        end
        ST_DECAY: begin
          if (lvl <= {1'b0, sl}) begin
            st_n  = ST_SUSTAIN;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_adv;
            if (fire) lvl_n = lvl_dec;
          end
        end
        ST_SUSTAIN: begin
          cnt_n = cnt_adv;
          if (fire && lvl != '0) lvl_n = lvl_dec;
        end
        ST_RELEASE: begin
          if (lvl == '0) begin
            st_n  = ST_IDLE;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_adv;
            if (fire) begin
              lvl_n = lvl_dec;
              if (lvl == ENV_BITS'(1)) st_n = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      st  <= ST_IDLE;
      lvl <= '0;
      cnt <= '0;
    end else begin
      st  <= st_n;
      lvl <= lvl_n;
      cnt <= cnt_n;
    end
  end

  assign lvl_nxt = lvl_n;
  assign st_nxt  = st_n;
endmodule

module wts_adsr_envelope_generator_nch #(
  parameter int CHANNELS  = 5,
  parameter int ENV_BITS  = 7,
  parameter int RATE_BITS = 8,
  parameter int IDX_W     = $clog2(CHANNELS + 1),
  parameter int SL_BITS   = ENV_BITS - 1
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [IDX_W-1:0]              active,
  input  logic [CHANNELS-1:0]           key_on,
  input  logic [CHANNELS-1:0]           key_release,
  input  logic [CHANNELS-1:0]           key_off,
  input  logic [CHANNELS-1:0]           reg_retrig,
  input  logic [CHANNELS*RATE_BITS-1:0] reg_ar,
  input  logic [CHANNELS*RATE_BITS-1:0] reg_dr,
  input  logic [CHANNELS*RATE_BITS-1:0] reg_sr,
  input  logic [CHANNELS*RATE_BITS-1:0] reg_rr,
  input  logic [CHANNELS*SL_BITS-1:0]   reg_sl,
  output logic [ENV_BITS-1:0]           envelope,
  output logic [2:0]                    phase
);
  logic [CHANNELS-1:0][ENV_BITS-1:0] lvl_nxt;
  logic [CHANNELS-1:0][2:0]          st_nxt;
  logic [ENV_BITS-1:0]               sel_lvl;
  logic [2:0]                        sel_st;
  logic                              sel_hit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    wts_adsr_ch #(.ENV_BITS(ENV_BITS), .RATE_BITS(RATE_BITS)) u_ch (
      .clk         (clk),
      .nreset      (nreset),
      .svc         (active == IDX_W'(g)),
      .key_on      (key_on[g]),
      .key_release (key_release[g]),
      .key_off     (key_off[g]),
      .retrig      (reg_retrig[g]),
      .ar          (reg_ar[g*RATE_BITS +: RATE_BITS]),
      .dr          (reg_dr[g*RATE_BITS +: RATE_BITS]),
      .sr          (reg_sr[g*RATE_BITS +: RATE_BITS]),
      .rr          (reg_rr[g*RATE_BITS +: RATE_BITS]),
      .sl          (reg_sl[g*SL_BITS +: SL_BITS]),
      .lvl_nxt     (lvl_nxt[g]),
      .st_nxt      (st_nxt[g])
    );
  end

  // Post-update values of the serviced channel; no hit for out-of-range slots.
  always_comb begin
    sel_lvl = '0;
    sel_st  = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active == IDX_W'(i)) begin
        sel_lvl = lvl_nxt[i];
        sel_st  = st_nxt[i];
        sel_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      envelope <= '0;
      phase    <= '0;
    end else if (sel_hit) begin
      envelope <= sel_lvl;
      phase    <= sel_st;
    end
  end
endmodule
